// File: rtl/rx_data_field_controller.sv
// 802.11a receive DATA-field sequencer: recovers the descrambler seed from SERVICE, descrambles
// and delivers PSDU bits, and discards SERVICE/TAIL/PAD. Optional macro: RX_SERVICE_CHECK_EN.
module rx_data_field_controller #(
  parameter int SERVICE_BITS = 16,
  parameter int TAIL_BITS    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signal_valid,
  input  logic [3:0]  signal_rate,
  input  logic [11:0] signal_length,
  input  logic        signal_error,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic        rate_error
`ifdef RX_SERVICE_CHECK_EN
  ,
  output logic        service_error
`endif
);

  typedef enum logic [2:0] {IDLE, SEED, SERVICE, PSDU, TAIL, PAD} state_t;

  state_t      state, state_n;
  logic [7:1]  lfsr, lfsr_n;
  logic [14:0] cnt, cnt_n;
  logic [7:0]  sym_cnt, sym_cnt_n;
  logic [7:0]  n_dbps, n_dbps_n;
  logic [11:0] len_q, len_n;
  logic        data_out_n, data_valid_n, done_n, rate_error_n;
  logic        fb, sym_wrap, frame_ok;
  logic [7:0]  dbps_dec;
  logic [14:0] psdu_last;

  function automatic logic [7:0] rate_to_dbps(input logic [3:0] rate);
    case (rate)
      4'b1101: rate_to_dbps = 8'd24;
      4'b1111: rate_to_dbps = 8'd36;
      4'b0101: rate_to_dbps = 8'd48;
      4'b0111: rate_to_dbps = 8'd72;
      4'b1001: rate_to_dbps = 8'd96;
      4'b1011: rate_to_dbps = 8'd144;
      4'b0001: rate_to_dbps = 8'd192;
      4'b0011: rate_to_dbps = 8'd216;
      default: rate_to_dbps = 8'd0;
    endcase
  endfunction

  assign fb        = lfsr[7] ^ lfsr[4];
  assign sym_wrap  = (sym_cnt == n_dbps - 8'd1);
  assign dbps_dec  = rate_to_dbps(signal_rate);
  assign frame_ok  = (dbps_dec != 8'd0) && (signal_length != 12'd0) && !signal_error;
  assign psdu_last = {len_q, 3'b000} - 15'd1;
  assign busy      = (state != IDLE);

`ifdef RX_SERVICE_CHECK_EN
  logic service_error_n;
`endif

  always_comb begin
    state_n      = state;
    lfsr_n       = lfsr;
    cnt_n        = cnt;
    sym_cnt_n    = sym_cnt;
    n_dbps_n     = n_dbps;
    len_n        = len_q;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    done_n       = 1'b0;
    rate_error_n = rate_error;
`ifdef RX_SERVICE_CHECK_EN
    service_error_n = service_error;
`endif
    if (state == IDLE) begin
      if (signal_valid) begin
        if (frame_ok) begin
          rate_error_n = 1'b0;
          n_dbps_n     = dbps_dec;
          len_n        = signal_length;
          cnt_n        = '0;
          sym_cnt_n    = '0;
          state_n      = SEED;
`ifdef RX_SERVICE_CHECK_EN
          service_error_n = 1'b0;
`endif
        end else begin
          rate_error_n = 1'b1;
        end
      end
    end else if (bit_valid) begin
      // Every consumed bit advances the OFDM symbol position, whatever field it belongs to
      sym_cnt_n = sym_wrap ? 8'd0 : sym_cnt + 8'd1;
      cnt_n     = cnt + 15'd1;
      lfsr_n    = {lfsr[6:1], fb};
      case (state)
        SEED: begin
          lfsr_n = {lfsr[6:1], bit_in};
          if (cnt == 15'd6) begin
            cnt_n   = '0;
            state_n = SERVICE;
          end
        end
        SERVICE: begin
`ifdef RX_SERVICE_CHECK_EN
          if (bit_in ^ fb) service_error_n = 1'b1;
`endif
          if (cnt == 15'(SERVICE_BITS - 8)) begin
            cnt_n   = '0;
            state_n = PSDU;
          end
        end
        PSDU: begin
          data_out_n   = bit_in ^ fb;
          data_valid_n = 1'b1;
          if (cnt == psdu_last) begin
            cnt_n   = '0;
            state_n = TAIL;
          end
        end
        TAIL: begin
          if (cnt == 15'(TAIL_BITS - 1)) begin
            cnt_n = '0;
            if (sym_wrap) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = PAD;
            end
          end
        end
        PAD: begin
          if (sym_wrap) begin
            cnt_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      cnt        <= '0;
      sym_cnt    <= '0;
      n_dbps     <= '0;
      len_q      <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      rate_error <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      cnt        <= cnt_n;
      sym_cnt    <= sym_cnt_n;
      n_dbps     <= n_dbps_n;
      len_q      <= len_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      done       <= done_n;
      rate_error <= rate_error_n;
    end
  end

`ifdef RX_SERVICE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) service_error <= 1'b0;
    else        service_error <= service_error_n;
  end
`endif

endmodule

// File: tb/tb_rx_data_field_controller.sv
// Scoreboard bench for rx_data_field_controller: frames are scrambled by a reference scrambler,
// expected PSDU bits are queued as they are driven and a monitor compares every Data_valid output.
module tb_rx_data_field_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        signal_valid;
  logic [3:0]  signal_rate;
  logic [11:0] signal_length;
  logic        signal_error;
  logic        bit_in;
  logic        bit_valid;
  logic        data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        rate_error;
`ifdef RX_SERVICE_CHECK_EN
  logic        service_error;
`endif

  rx_data_field_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_valid  (signal_valid),
    .signal_rate   (signal_rate),
    .signal_length (signal_length),
    .signal_error  (signal_error),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .done          (done),
    .rate_error    (rate_error)
`ifdef RX_SERVICE_CHECK_EN
    ,
    .service_error (service_error)
`endif
  );

  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   dv_cnt    = 0;
  int   done_cnt  = 0;
  logic exp_q[$];
  logic fr_bit[$];
  logic fr_psdu[$];
  logic fr_data[$];

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: compares every delivered bit against the head of the scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (data_valid === 1'b1) begin
      dv_cnt++;
      if (exp_q.size() == 0) chk("unexpected_data_valid", 1, 0);
      else chk("data_out", int'(data_out), int'(exp_q.pop_front()));
    end
  end

  // Reference transmit scrambler: seed_rx gives the first 7 received bits (= scrambler state)
  task automatic build_frame(input logic [6:0] seed_rx, input int len, input logic [7:0] base,
                             input bit zero_data, input int total);
    logic [7:1] s;
    logic [7:0] byte_v;
    logic       d, f;
    int         idx;
    fr_bit.delete(); fr_psdu.delete(); fr_data.delete();
    s = seed_rx;
    for (int i = 0; i < 7; i++) begin
      fr_bit.push_back(seed_rx[6-i]); fr_psdu.push_back(1'b0); fr_data.push_back(1'b0);
    end
    for (int i = 7; i < total; i++) begin
      idx = i - 16;
      d   = 1'b0;
      if (idx >= 0 && idx < 8 * len) begin
        byte_v = zero_data ? 8'h00 : base + 8'(29 * (idx / 8));
        d = byte_v[idx % 8];
      end
      f = s[7] ^ s[4];
      s = {s[6:1], f};
      fr_bit.push_back(d ^ f);
      fr_psdu.push_back(idx >= 0 && idx < 8 * len);
      fr_data.push_back(d);
    end
  endtask

  task automatic run_frame(input string nm, input logic [3:0] rate, input int len,
                           input logic [6:0] seed_rx, input logic [7:0] base, input bit zero_data,
                           input int total, input bit gap, input bit inject, input int exp_dv);
    bit early_done = 0, busy_drop = 0;
    build_frame(seed_rx, len, base, zero_data, total);
    @(negedge clk);
    signal_valid = 1'b1; signal_rate = rate; signal_length = 12'(len); signal_error = 1'b0;
    @(negedge clk);
    signal_valid = 1'b0;
    chk({nm, "_busy_after_accept"}, int'(busy), 1);
    chk({nm, "_rate_error_cleared"}, int'(rate_error), 0);
    dv_cnt = 0; done_cnt = 0;
    for (int i = 0; i < total; i++) begin
      bit_valid = 1'b1; bit_in = fr_bit[i];
      signal_valid = inject && (i == 100);
      signal_error = inject && (i == 100);
      if (fr_psdu[i]) exp_q.push_back(fr_data[i]);
      @(negedge clk);
      signal_valid = 1'b0; signal_error = 1'b0;
      if (i < total - 1) begin
        if (done) early_done = 1;
        if (!busy) busy_drop = 1;
        if (gap && fr_psdu[i]) begin
          bit_valid = 1'b0;
          @(negedge clk);
          if (done) early_done = 1;
          if (!busy) busy_drop = 1;
        end
      end
    end
    bit_valid = 1'b0;
    chk({nm, "_done_after_last_bit"}, int'(done), 1);
    chk({nm, "_busy_low_at_done"}, int'(busy), 0);
    chk({nm, "_no_early_done"}, int'(early_done), 0);
    chk({nm, "_busy_whole_frame"}, int'(busy_drop), 0);
    repeat (3) @(negedge clk);
    chk({nm, "_data_valid_count"}, dv_cnt, exp_dv);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
    chk({nm, "_rate_error_end"}, int'(rate_error), 0);
  endtask

  task automatic bad_signal(input string nm, input logic [3:0] rate, input int len, input logic err);
    @(negedge clk);
    signal_valid = 1'b1; signal_rate = rate; signal_length = 12'(len); signal_error = err;
    @(negedge clk);
    signal_valid = 1'b0; signal_error = 1'b0;
    chk({nm, "_rate_error"}, int'(rate_error), 1);
    dv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; bit_in = i[0];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_stays_low"}, int'(busy), 0);
    chk({nm, "_no_data_valid"}, dv_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; signal_valid = 1'b0; signal_rate = 4'h0; signal_length = 12'd0;
    signal_error = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({data_out, data_valid, busy, done, rate_error}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Rate 6 Mb/s, one octet: 16+8+6 = 30 bits, padded to 48
    run_frame("r24_len1", 4'b1101, 1, 7'b1011101, 8'hA5, 1'b0, 48, 1'b0, 1'b0, 8);
    // Rate 54 Mb/s, 100 octets: 822 bits padded to 864; a bad SIGNAL mid-frame must be ignored
    run_frame("r216_len100", 4'b0011, 100, 7'b0110010, 8'h3C, 1'b0, 864, 1'b0, 1'b1, 800);
    // Reference scrambler seeded 1111111 emits 0000111 first; all-zero PSDU, 46 -> 48
    run_frame("r48_zero", 4'b0101, 3, 7'b0000111, 8'h00, 1'b1, 48, 1'b0, 1'b0, 24);

    bad_signal("bad_rate", 4'b0000, 5, 1'b0);
    bad_signal("len_zero", 4'b1101, 0, 1'b0);
    bad_signal("sig_error", 4'b1101, 5, 1'b1);

    // Toggling Bit_valid in PSDU: 16+16+6 = 38 -> 48
    run_frame("r24_gap", 4'b1101, 2, 7'b1011101, 8'hA5, 1'b0, 48, 1'b1, 1'b0, 16);

    // Reset mid-PSDU at 9 Mb/s, 4 octets
    build_frame(7'b1100101, 4, 8'h77, 1'b0, 72);
    @(negedge clk);
    signal_valid = 1'b1; signal_rate = 4'b1111; signal_length = 12'd4;
    @(negedge clk);
    signal_valid = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      bit_valid = 1'b1; bit_in = fr_bit[i];
      if (fr_psdu[i]) exp_q.push_back(fr_data[i]);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", int'({data_out, data_valid, busy, done}), 0);
    chk("abort_scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run_frame("after_abort", 4'b1101, 1, 7'b1011101, 8'h5A, 1'b0, 48, 1'b0, 1'b0, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
